pipe_spawn_ctrl: RTL and testbench

// - Command-side controller for the pipe position counter: drives its respawn, move-enable and speed-increment inputs.
// - Consumes the counter's pipe-out flag and position.
// - Owns the game flow (idle / run / game over), the pseudo-random gap height, the score and the speed-up schedule.
// - Sits between the button/collision logic and the pipe position counter; gap and score feed the VGA draw logic.

---
 rtl/pipe_spawn_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_spawn_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_spawn_ctrl.sv
// Game-flow controller that commands the pipe position counter and owns the gap height, score and speed-up schedule.
// Optional HIGHSCORE_EN adds a high-score register and the oHighScore port.
//
// state  | meaning
// IDLE   | waiting for the first start press, pipe parked
// LAUNCH | one-cycle respawn of the pipe with a fresh gap height
// RUN    | pipe moving, scoring armed until the pipe passes the bird
// OVER   | collision seen, waiting for start to replay
module pipe_spawn_ctrl #(
    parameter int          H_TOT      = 800,
    parameter int          BIRD_X     = 120,
    parameter int          GAP_MIN    = 100,
    parameter int          GAP_RLOG2  = 8,
    parameter int          SCORE_STEP = 5,
    parameter int          SCORE_MAX  = 999,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          P_SIZE     = $clog2(H_TOT)
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic              iCollision,
    input  logic              iPipeOut,
    input  logic [P_SIZE-1:0] iPipePos,
    output logic              oPosRst,
    output logic              oPosMove,
    output logic              oPipeSpeedInc,
    output logic [9:0]        oGapY,
    output logic [9:0]        oScore,
`ifdef HIGHSCORE_EN
    output logic [9:0]        oHighScore,
`endif
    output logic              oGameOver
);

    localparam int SW = $clog2(SCORE_STEP + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [9:0]     gap_q, gap_d;
    logic [9:0]     score_q, score_d;
    logic           armed_q, armed_d;
    logic [SW-1:0]  step_q, step_d;
    logic [SW-1:0]  step_inc;
    logic           spd_q, spd_d;
    logic           lfsr_fb;
`ifdef HIGHSCORE_EN
    logic [9:0]     hs_q, hs_d;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            gap_q   <= 10'(GAP_MIN);
            score_q <= '0;
            armed_q <= 1'b0;
            step_q  <= '0;
            spd_q   <= 1'b0;
`ifdef HIGHSCORE_EN
            hs_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            gap_q   <= gap_d;
            score_q <= score_d;
            armed_q <= armed_d;
            step_q  <= step_d;
            spd_q   <= spd_d;
`ifdef HIGHSCORE_EN
            hs_q    <= hs_d;
`endif
        end
    end

    // Fibonacci taps 16,14,13,11; free-running so the gap depends on when start is pressed
    assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign step_inc = step_q + SW'(1);

    always_comb begin
        state_d = state_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
        gap_d   = gap_q;
        score_d = score_q;
        armed_d = armed_q;
        step_d  = step_q;
        spd_d   = 1'b0;
`ifdef HIGHSCORE_EN
        hs_d    = hs_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (iStart) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                armed_d = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (iCollision) begin
                    state_d = S_OVER;
                end else if (iPipeOut) begin
                    state_d = S_LAUNCH;
                end else if (armed_q && (iPipePos < P_SIZE'(BIRD_X))) begin
                    armed_d = 1'b0;
                    if (score_q < 10'(SCORE_MAX)) begin
                        score_d = score_q + 10'd1;
                        if (step_inc == SW'(SCORE_STEP)) begin
                            step_d = '0;
                            spd_d  = 1'b1;
                        end else begin
                            step_d = step_inc;
                        end
                    end
                end
            end
            S_OVER: begin
                if (iStart) begin
                    score_d = '0;
                    step_d  = '0;
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // gap sampled from the LFSR value present on the edge that enters LAUNCH
        if ((state_d == S_LAUNCH) && (state_q != S_LAUNCH))
            gap_d = 10'(GAP_MIN) + 10'(lfsr_q[GAP_RLOG2-1:0]);

`ifdef HIGHSCORE_EN
        if ((state_d == S_OVER) && (state_q != S_OVER) && (score_q > hs_q))
            hs_d = score_q;
`endif
    end

    assign oPosRst       = (state_q == S_LAUNCH);
    assign oPosMove      = (state_q == S_RUN);
    assign oGameOver     = (state_q == S_OVER);
    assign oPipeSpeedInc = spd_q;
    assign oGapY         = gap_q;
    assign oScore        = score_q;
`ifdef HIGHSCORE_EN
    assign oHighScore    = hs_q;
`endif

endmodule

// File: tb/tb_pipe_spawn_ctrl.sv
// Directed self-checking bench for pipe_spawn_ctrl; gap expectations come from an independent LFSR model.
module tb_pipe_spawn_ctrl;

    logic       clk_sys = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       coll = 1'b0;
    logic       pipe_out = 1'b0;
    logic [9:0] pipe_pos = 10'd799;
    logic       pos_rst, pos_move, spd_inc, game_over;
    logic [9:0] gap_y, score;
`ifdef HIGHSCORE_EN
    logic [9:0] high_score;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_score = 0;
    logic [9:0] exp_gap;
    logic [15:0] m_lfsr;

    pipe_spawn_ctrl dut (
        .iClk          (clk_sys),
        .iRst          (rst),
        .iStart        (start),
        .iCollision    (coll),
        .iPipeOut      (pipe_out),
        .iPipePos      (pipe_pos),
        .oPosRst       (pos_rst),
        .oPosMove      (pos_move),
        .oPipeSpeedInc (spd_inc),
        .oGapY         (gap_y),
        .oScore        (score),
`ifdef HIGHSCORE_EN
        .oHighScore    (high_score),
`endif
        .oGameOver     (game_over)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // one pipe passing the bird and scoring, then respawn back into RUN
    task automatic play_pipe();
        pipe_pos = 10'd150;
        tick();
        pipe_pos = 10'd119;
        tick();
        exp_score++;
        check_eq("pipe_score", 32'(score), 32'(exp_score));
        check_eq("pipe_spd", 32'(spd_inc), 32'(exp_score % 5 == 0));
        pipe_pos = 10'd0;
        tick();
        check_eq("pipe_spd_clr", 32'(spd_inc), 32'd0);
        pipe_out = 1'b1;
        pipe_pos = 10'd799;
        exp_gap  = 10'd100 + 10'(m_lfsr[7:0]);
        tick();
        pipe_out = 1'b0;
        check_eq("respawn_rst", 32'(pos_rst), 32'd1);
        check_eq("respawn_gap", 32'(gap_y), 32'(exp_gap));
        tick();
        check_eq("respawn_move", 32'(pos_move), 32'd1);
    endtask

    initial begin
        tick();
        tick();
        check_eq("rst_posrst", 32'(pos_rst), 32'd0);
        check_eq("rst_move", 32'(pos_move), 32'd0);
        check_eq("rst_over", 32'(game_over), 32'd0);
        check_eq("rst_spd", 32'(spd_inc), 32'd0);
        check_eq("rst_gap", 32'(gap_y), 32'd100);
        check_eq("rst_score", 32'(score), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check_eq("idle_move", 32'(pos_move), 32'd0);

        // first launch
        start   = 1'b1;
        exp_gap = 10'd100 + 10'(m_lfsr[7:0]);
        tick();
        start = 1'b0;
        check_eq("launch_rst", 32'(pos_rst), 32'd1);
        check_eq("launch_move", 32'(pos_move), 32'd0);
        check_eq("launch_gap", 32'(gap_y), 32'(exp_gap));
        check_eq("gap_range", 32'(gap_y >= 10'd100 && gap_y <= 10'd355), 32'd1);
        tick();
        check_eq("run_rst", 32'(pos_rst), 32'd0);
        check_eq("run_move", 32'(pos_move), 32'd1);

        // sweep the pipe past the bird
        for (int p = 150; p >= 0; p--) begin
            pipe_pos = 10'(p);
            tick();
            if (p == 120) check_eq("sweep_120", 32'(score), 32'd0);
            if (p == 119) begin
                check_eq("sweep_119", 32'(score), 32'd1);
                check_eq("sweep_spd", 32'(spd_inc), 32'd0);
            end
        end
        check_eq("sweep_once", 32'(score), 32'd1);
        exp_score = 1;
        pipe_out  = 1'b1;
        pipe_pos  = 10'd799;
        exp_gap   = 10'd100 + 10'(m_lfsr[7:0]);
        tick();
        pipe_out = 1'b0;
        check_eq("sweep_respawn", 32'(pos_rst), 32'd1);
        check_eq("sweep_gap", 32'(gap_y), 32'(exp_gap));
        tick();
        check_eq("sweep_move", 32'(pos_move), 32'd1);

        // score 2..7, speed pulse only at 5
        for (int i = 0; i < 6; i++) play_pipe();

        // start ignored while running
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("run_start_ign", 32'(pos_rst), 32'd0);
        check_eq("run_start_move", 32'(pos_move), 32'd1);

        // collision beats scoring
        pipe_pos = 10'd150;
        tick();
        pipe_pos = 10'd119;
        coll     = 1'b1;
        tick();
        coll = 1'b0;
        check_eq("coll_over", 32'(game_over), 32'd1);
        check_eq("coll_score", 32'(score), 32'd7);
        check_eq("coll_move", 32'(pos_move), 32'd0);
        check_eq("coll_posrst", 32'(pos_rst), 32'd0);
        pipe_out = 1'b1;
        tick();
        pipe_out = 1'b0;
        check_eq("over_pipeout_ign", 32'(pos_rst), 32'd0);
        check_eq("over_hold", 32'(game_over), 32'd1);
`ifdef HIGHSCORE_EN
        check_eq("hs_first", 32'(high_score), 32'd7);
`endif

        // restart clears score and step count
        start   = 1'b1;
        exp_gap = 10'd100 + 10'(m_lfsr[7:0]);
        tick();
        start = 1'b0;
        check_eq("restart_score", 32'(score), 32'd0);
        check_eq("restart_rst", 32'(pos_rst), 32'd1);
        check_eq("restart_over", 32'(game_over), 32'd0);
        check_eq("restart_gap", 32'(gap_y), 32'(exp_gap));
        tick();
        check_eq("restart_move", 32'(pos_move), 32'd1);
        exp_score = 0;
        for (int i = 0; i < 3; i++) play_pipe();
        coll = 1'b1;
        tick();
        coll = 1'b0;
        check_eq("second_over", 32'(game_over), 32'd1);
        check_eq("second_score", 32'(score), 32'd3);
`ifdef HIGHSCORE_EN
        check_eq("hs_kept", 32'(high_score), 32'd7);
`endif

        // step counter cleared on restart: next pulse only at score 5
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        exp_score = 0;
        for (int i = 0; i < 5; i++) play_pipe();

        // async reset mid-run
        pipe_pos = 10'd150;
        tick();
        pipe_pos = 10'd119;
        tick();
        check_eq("pre_rst_score", 32'(score), 32'd6);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_move", 32'(pos_move), 32'd0);
        check_eq("arst_posrst", 32'(pos_rst), 32'd0);
        check_eq("arst_over", 32'(game_over), 32'd0);
        check_eq("arst_spd", 32'(spd_inc), 32'd0);
        check_eq("arst_score", 32'(score), 32'd0);
        check_eq("arst_gap", 32'(gap_y), 32'd100);
`ifdef HIGHSCORE_EN
        check_eq("arst_hs", 32'(high_score), 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        check_eq("post_rst_idle", 32'(pos_move), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
